// File: rtl/irr_pkg.sv
// Shared types and helpers for the multi-zone irrigation scheduler.
package irr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    RUN,
    FAULT
  } state_t;

  typedef enum logic {
    DRIP,
    SPRAY
  } mode_t;

  // Sensor combinations that cannot occur with a healthy float-switch stack.
  function automatic logic tank_fault(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l) | (h & ~l);
  endfunction

endpackage

// File: rtl/irr_tick_gen.sv
// 1 s prescaler: emits a single-cycle tick every TICK_DIV clocks, restartable by clear.
module irr_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation controller: tank supervision plus round-robin drip/spray
// scheduling of N_ZONES beds, each run timed in whole seconds.
module irrigation_zone_scheduler
  import irr_pkg::*;
#(
  parameter int N_ZONES  = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int GT_SECS  = 10,
  parameter int AS_SECS  = 5,
  parameter int TW       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       h,
  input  logic                       m,
  input  logic                       l,
  input  logic                       t,
  input  logic [N_ZONES-1:0]         us,
  input  logic [N_ZONES-1:0]         ua,
  input  logic [N_ZONES-1:0]         zone_en,
  output logic                       alarme,
  output logic                       valve_in,
  output logic [N_ZONES-1:0]         drip,
  output logic [N_ZONES-1:0]         spray,
  output logic [$clog2(N_ZONES)-1:0] active_zone,
  output logic                       busy,
  output logic [TW-1:0]              secs_left,
  output logic                       run_done
);

  localparam int ZW = $clog2(N_ZONES);

  state_t          state;
  state_t          state_n;
  mode_t           mode;
  logic [ZW-1:0]   ptr;
  logic [ZW-1:0]   zone;
  logic [ZW-1:0]   zone_inc;
  logic [ZW-1:0]   pick;
  logic [ZW-1:0]   idx;
  logic [ZW:0]     sum;
  logic            found;
  logic            pick_drip;
  logic            fault;
  logic            alarm_d;
  logic            tick;
  logic            run_tick;
  logic            last_sec;
  logic            zone_dry;
  logic [N_ZONES-1:0] need;
  logic [N_ZONES-1:0] elig;
  logic [N_ZONES-1:0] zone_hot;

  assign fault   = tank_fault(h, m, l);
  assign alarm_d = fault | ~l;

  // A bed is only eligible if the tank can feed the mode it would run in.
  assign need = zone_en & us;
  assign elig = need & ((ua | {N_ZONES{t}}) & {N_ZONES{l}} | ~(ua | {N_ZONES{t}}) & {N_ZONES{m}});

  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_drip = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_ZONES; k++) begin
      sum = {1'b0, ptr} + (ZW+1)'(k);
      if (sum >= (ZW+1)'(N_ZONES)) begin
        sum = sum - (ZW+1)'(N_ZONES);
      end
      idx = sum[ZW-1:0];
      if (!found && elig[idx]) begin
        found     = 1'b1;
        pick      = idx;
        pick_drip = ua[idx] | t;
      end
    end
  end

  irr_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state == SELECT),
    .tick (tick)
  );

  assign zone_inc = (zone == ZW'(N_ZONES - 1)) ? '0 : zone + 1'b1;
  assign run_tick = (state == RUN) && tick && !alarm_d;
  assign last_sec = (secs_left <= TW'(1));
  assign zone_dry = us[zone];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|need) state_n = SELECT;
      SELECT:  state_n = found ? RUN : IDLE;
      RUN:     if (tick && (!zone_dry || last_sec)) state_n = IDLE;
      FAULT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The alarm overrides every state, so FAULT and the registered alarm line up.
    if (alarm_d) state_n = FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= DRIP;
      ptr       <= '0;
      zone      <= '0;
      secs_left <= '0;
      run_done  <= 1'b0;
      alarme    <= 1'b0;
      valve_in  <= 1'b0;
    end else begin
      state    <= state_n;
      alarme   <= alarm_d;
      run_done <= run_tick && zone_dry && last_sec;
      if (h | fault) begin
        valve_in <= 1'b0;
      end else if (~m) begin
        valve_in <= 1'b1;
      end
      if (state == SELECT && found && !alarm_d) begin
        zone <= pick;
        mode <= pick_drip ? DRIP : SPRAY;
      end
      if (run_tick && (!zone_dry || last_sec)) begin
        ptr <= zone_inc;
      end
      if (state_n != RUN) begin
        secs_left <= '0;
      end else if (state == SELECT) begin
        secs_left <= pick_drip ? TW'(GT_SECS) : TW'(AS_SECS);
      end else if (tick && secs_left != '0) begin
        secs_left <= secs_left - 1'b1;
      end
    end
  end

  assign busy        = (state == RUN);
  assign zone_hot    = busy ? (N_ZONES'(1) << zone) : '0;
  assign drip        = (mode == DRIP)  ? zone_hot : '0;
  assign spray       = (mode == SPRAY) ? zone_hot : '0;
  assign active_zone = busy ? zone : '0;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler with a fast 4-cycle tick.
module tb_irrigation_zone_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       h, m, l, t;
  logic [3:0] us, ua, zone_en;
  logic       alarme, valve_in, busy, run_done;
  logic [3:0] drip, spray;
  logic [1:0] active_zone;
  logic [7:0] secs_left;

  int check_count = 0;
  int error_count = 0;

  irrigation_zone_scheduler #(
    .N_ZONES (4),
    .TICK_DIV(4),
    .GT_SECS (3),
    .AS_SECS (2),
    .TW      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h          (h),
    .m          (m),
    .l          (l),
    .t          (t),
    .us         (us),
    .ua         (ua),
    .zone_en    (zone_en),
    .alarme     (alarme),
    .valve_in   (valve_in),
    .drip       (drip),
    .spray      (spray),
    .active_zone(active_zone),
    .busy       (busy),
    .secs_left  (secs_left),
    .run_done   (run_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic th, input logic tm, input logic tl, input logic tt,
                               input logic [3:0] tus, input logic [3:0] tua, input logic [3:0] ten);
    h = th; m = tm; l = tl; t = tt;
    us = tus; ua = tua; zone_en = ten;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 1, 1, 0, 4'h0, 4'h0, 4'h0);
    stepCycles(2);
    checkOutput("rst_alarme", 32'(alarme), 32'd0);
    checkOutput("rst_valve", 32'(valve_in), 32'd0);
    checkOutput("rst_drip", 32'(drip), 32'd0);
    checkOutput("rst_spray", 32'(spray), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_secs", 32'(secs_left), 32'd0);
    checkOutput("rst_done", 32'(run_done), 32'd0);
    rst = 1'b0;
    stepCycles(3);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_valve", 32'(valve_in), 32'd0);

    $display("[TB] round-robin spray on zones 0 and 2");
    applyStimulus(1, 1, 1, 0, 4'b0101, 4'b0000, 4'hF);
    stepCycles(2);
    checkOutput("s1_spray0", 32'(spray), 32'h1);
    checkOutput("s1_drip0", 32'(drip), 32'h0);
    checkOutput("s1_busy", 32'(busy), 32'd1);
    checkOutput("s1_zone0", 32'(active_zone), 32'd0);
    checkOutput("s1_secs2", 32'(secs_left), 32'd2);
    stepCycles(4);
    checkOutput("s1_secs1", 32'(secs_left), 32'd1);
    stepCycles(3);
    checkOutput("s1_spray_last", 32'(spray), 32'h1);
    checkOutput("s1_done_early", 32'(run_done), 32'd0);
    stepCycles(1);
    checkOutput("s1_spray_off", 32'(spray), 32'h0);
    checkOutput("s1_done", 32'(run_done), 32'd1);
    checkOutput("s1_secs0", 32'(secs_left), 32'd0);
    stepCycles(2);
    checkOutput("s1_spray2", 32'(spray), 32'h4);
    checkOutput("s1_zone2", 32'(active_zone), 32'd2);
    stepCycles(8);
    checkOutput("s1_done2", 32'(run_done), 32'd1);

    $display("[TB] drip on zone 1, pointer starts at 3");
    applyStimulus(0, 1, 1, 0, 4'b0010, 4'b0010, 4'hF);
    stepCycles(2);
    checkOutput("s2_drip1", 32'(drip), 32'h2);
    checkOutput("s2_spray", 32'(spray), 32'h0);
    checkOutput("s2_zone1", 32'(active_zone), 32'd1);
    checkOutput("s2_secs3", 32'(secs_left), 32'd3);
    stepCycles(4);
    checkOutput("s2_secs2", 32'(secs_left), 32'd2);
    stepCycles(4);
    checkOutput("s2_secs1", 32'(secs_left), 32'd1);
    stepCycles(4);
    checkOutput("s2_secs0", 32'(secs_left), 32'd0);
    checkOutput("s2_done", 32'(run_done), 32'd1);
    checkOutput("s2_drip_off", 32'(drip), 32'h0);
    applyStimulus(0, 1, 1, 0, 4'b0000, 4'b0010, 4'hF);
    stepCycles(1);
    checkOutput("s2_done_once", 32'(run_done), 32'd0);
    checkOutput("s2_valve_hold", 32'(valve_in), 32'd0);

    $display("[TB] tank drain: spray skipped, drip allowed");
    applyStimulus(0, 0, 1, 0, 4'b0101, 4'b0001, 4'hF);
    stepCycles(1);
    checkOutput("s3_valve_on", 32'(valve_in), 32'd1);
    checkOutput("s3_alarm", 32'(alarme), 32'd0);
    stepCycles(1);
    checkOutput("s3_drip0", 32'(drip), 32'h1);
    checkOutput("s3_spray", 32'(spray), 32'h0);
    checkOutput("s3_zone0", 32'(active_zone), 32'd0);
    stepCycles(12);
    checkOutput("s3_done", 32'(run_done), 32'd1);
    applyStimulus(1, 1, 1, 0, 4'b0000, 4'b0000, 4'hF);
    stepCycles(1);
    checkOutput("s3_valve_off", 32'(valve_in), 32'd0);

    $display("[TB] alarm mid-run keeps pointer");
    applyStimulus(1, 1, 1, 0, 4'b0110, 4'b0000, 4'hF);
    stepCycles(2);
    checkOutput("s4_spray1", 32'(spray), 32'h2);
    checkOutput("s4_zone1", 32'(active_zone), 32'd1);
    stepCycles(2);
    applyStimulus(1, 0, 1, 0, 4'b0110, 4'b0000, 4'hF);
    stepCycles(1);
    checkOutput("s4_alarm", 32'(alarme), 32'd1);
    checkOutput("s4_spray_off", 32'(spray), 32'h0);
    checkOutput("s4_drip_off", 32'(drip), 32'h0);
    checkOutput("s4_busy", 32'(busy), 32'd0);
    checkOutput("s4_no_done", 32'(run_done), 32'd0);
    stepCycles(2);
    checkOutput("s4_alarm_hold", 32'(alarme), 32'd1);
    checkOutput("s4_busy_hold", 32'(busy), 32'd0);
    applyStimulus(1, 1, 1, 0, 4'b0110, 4'b0000, 4'hF);
    stepCycles(1);
    checkOutput("s4_alarm_clr", 32'(alarme), 32'd0);
    stepCycles(2);
    checkOutput("s4_rerun_spray", 32'(spray), 32'h2);
    checkOutput("s4_rerun_zone", 32'(active_zone), 32'd1);
    checkOutput("s4_rerun_secs", 32'(secs_left), 32'd2);

    $display("[TB] soil wet mid-run stops at tick");
    stepCycles(1);
    applyStimulus(1, 1, 1, 0, 4'b0100, 4'b0000, 4'hF);
    stepCycles(2);
    checkOutput("s5_spray_hold", 32'(spray), 32'h2);
    stepCycles(1);
    checkOutput("s5_spray_off", 32'(spray), 32'h0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    checkOutput("s5_no_done", 32'(run_done), 32'd0);
    stepCycles(2);
    checkOutput("s5_next_spray", 32'(spray), 32'h4);
    checkOutput("s5_next_zone", 32'(active_zone), 32'd2);

    $display("[TB] reset mid-run");
    stepCycles(1);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("s6_spray", 32'(spray), 32'h0);
    checkOutput("s6_busy", 32'(busy), 32'd0);
    checkOutput("s6_zone", 32'(active_zone), 32'd0);
    checkOutput("s6_secs", 32'(secs_left), 32'd0);
    checkOutput("s6_done", 32'(run_done), 32'd0);
    rst = 1'b0;
    applyStimulus(1, 1, 1, 0, 4'b0000, 4'b0000, 4'hF);
    stepCycles(2);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
